// File: rtl/instruction_fetch_pkg.sv
// Shared opcodes, FSM encodings, queue entry layout and the static next-PC predictor
// used by the fetch front end.
package instruction_fetch_pkg;

  localparam int IQ_DEPTH_LOG_DEF = 3;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } iq_entry_t;

  // JAL is always followed, conditional branches only when backward (imm sign bit set).
  function automatic iq_entry_t predict(input logic [31:0] pc, input logic [31:0] w);
    iq_entry_t   e;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    j_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    b_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    e.inst       = w;
    e.pc         = pc;
    e.pred_taken = 1'b0;
    e.pred_pc    = pc + 32'd4;
    case (w[6:0])
      OPC_JAL: begin
        e.pred_taken = 1'b1;
        e.pred_pc    = pc + j_imm;
      end
      OPC_BRANCH: begin
        if (w[31]) begin
          e.pred_taken = 1'b1;
          e.pred_pc    = pc + b_imm;
        end
      end
      OPC_JALR: e.pred_taken = 1'b0;
      default:  e.pred_taken = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Instruction queue: circular FIFO of predicted fetch entries, head read straight
// from storage and forced to zero when empty.
module inst_queue
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH_LOG = IQ_DEPTH_LOG_DEF
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      en,
  input  logic      clear,
  input  logic      push,
  input  iq_entry_t push_data,
  input  logic      pop,
  output iq_entry_t head_data,
  output logic      valid,
  output logic      full
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);

  iq_entry_t            mem [DEPTH];
  logic [DEPTH_LOG-1:0] head_reg;
  logic [DEPTH_LOG-1:0] tail_reg;
  logic [DEPTH_LOG:0]   count_reg;
  logic                 do_pop;

  assign valid     = (count_reg != '0);
  assign full      = (count_reg == FULL_COUNT);
  assign do_pop    = pop && valid;
  assign head_data = valid ? mem[head_reg] : '0;

  always_ff @(posedge clk_in) begin
    if (en && !clear && push) begin
      mem[tail_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (en) begin
      if (clear) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push)   tail_reg <= tail_reg + 1'b1;
        if (do_pop) head_reg <= head_reg + 1'b1;
        if (push && !do_pop)      count_reg <= count_reg + 1'b1;
        else if (!push && do_pop) count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: PC register, single-outstanding icache request FSM and the
// static predictor feeding the instruction queue that drives decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          IQ_DEPTH_LOG = IQ_DEPTH_LOG_DEF,
  parameter logic [31:0] RESET_PC     = 32'h00000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic [31:0] clear_pc,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_req_ready,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_inst,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        iq_pred_taken,
  output logic [31:0] iq_pred_pc,
  input  logic        iq_ready
);

  logic [31:0] pc_reg;
  logic [1:0]  state_reg;
  logic        full;
  logic        push;
  logic        req_fire;
  iq_entry_t   push_data;
  iq_entry_t   head;

  assign push_data        = predict(pc_reg, icache_resp_inst);
  assign push             = (state_reg == ST_WAIT) && icache_resp_valid && !clear_in;
  assign icache_req_valid = !rst_in && (state_reg == ST_REQ) && !full;
  assign icache_req_addr  = pc_reg;
  assign req_fire         = icache_req_valid && icache_req_ready;

  // A flush never cancels a request already handed to the controller: its
  // response must still be swallowed, hence the detour through DROP.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_reg    <= RESET_PC;
      state_reg <= ST_REQ;
    end else if (rdy_in) begin
      if (clear_in) begin
        pc_reg <= clear_pc;
        case (state_reg)
          ST_REQ:  state_reg <= req_fire ? ST_DROP : ST_REQ;
          ST_WAIT: state_reg <= ST_DROP;
          default: state_reg <= ST_REQ;
        endcase
      end else begin
        case (state_reg)
          ST_REQ: if (req_fire) state_reg <= ST_WAIT;
          ST_WAIT: begin
            if (icache_resp_valid) begin
              pc_reg    <= push_data.pred_pc;
              state_reg <= ST_REQ;
            end
          end
          ST_DROP: if (icache_resp_valid) state_reg <= ST_REQ;
          default: state_reg <= ST_REQ;
        endcase
      end
    end
  end

  inst_queue #(
    .DEPTH_LOG(IQ_DEPTH_LOG)
  ) u_queue (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .clear     (clear_in),
    .push      (push),
    .push_data (push_data),
    .pop       (iq_ready),
    .head_data (head),
    .valid     (iq_valid),
    .full      (full)
  );

  assign iq_inst       = head.inst;
  assign iq_pc         = head.pc;
  assign iq_pred_taken = head.pred_taken;
  assign iq_pred_pc    = head.pred_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: table of prediction vectors plus
// hand-written sequences for full queue, flush, freeze and reset.
module tb_instruction_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic [31:0] clear_pc;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_req_ready, icache_resp_valid;
  logic [31:0] icache_resp_inst;
  logic        iq_valid, iq_pred_taken, iq_ready;
  logic [31:0] iq_inst, iq_pc, iq_pred_pc;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] pred_pc;
  } exp_t;

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] pred_pc;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_in = ~clk_in;

  instruction_fetch #(.IQ_DEPTH_LOG(3), .RESET_PC(32'h00000000)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .clear_in          (clear_in),
    .clear_pc          (clear_pc),
    .icache_req_valid  (icache_req_valid),
    .icache_req_addr   (icache_req_addr),
    .icache_req_ready  (icache_req_ready),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_inst  (icache_resp_inst),
    .iq_valid          (iq_valid),
    .iq_inst           (iq_inst),
    .iq_pc             (iq_pc),
    .iq_pred_taken     (iq_pred_taken),
    .iq_pred_pc        (iq_pred_pc),
    .iq_ready          (iq_ready)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: got head pc %h expected no entry", iq_pc);
    end else begin
      e = sb.pop_front();
      chk("head_valid", iq_valid, 1);
      chk("head_inst", iq_inst, e.inst);
      chk("head_pc", iq_pc, e.pc);
      chk("head_taken", iq_pred_taken, e.taken);
      chk("head_pred_pc", iq_pred_pc, e.pred_pc);
    end
  endtask

  task automatic pop_check();
    compare_head();
    iq_ready = 1'b1;
    tick();
    iq_ready = 1'b0;
  endtask

  // Request accepted, response word two cycles later; optional same-cycle pop.
  task automatic fetch(input logic [31:0] w, input logic taken, input logic [31:0] pred,
                       input bit pop_same);
    int t = 0;
    while (!icache_req_valid && t < 50) begin
      tick();
      t++;
    end
    chk("req_valid_before_fetch", icache_req_valid, 1);
    sb.push_back('{w, icache_req_addr, taken, pred});
    icache_req_ready = 1'b1;
    tick();
    icache_req_ready = 1'b0;
    chk("req_low_in_wait", icache_req_valid, 0);
    tick();
    icache_resp_valid = 1'b1;
    icache_resp_inst  = w;
    if (pop_same) begin
      compare_head();
      iq_ready = 1'b1;
    end
    tick();
    icache_resp_valid = 1'b0;
    iq_ready          = 1'b0;
    chk("push_visible_next_cycle", iq_valid, 1);
  endtask

  task automatic redirect(input logic [31:0] target);
    clear_in = 1'b1;
    clear_pc = target;
    tick();
    clear_in = 1'b0;
    sb.delete();
    chk("redirect_addr", icache_req_addr, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{32'h00000010, 32'h0080006F, 1'b1, 32'h00000018};
    vecs[1] = '{32'h00000020, 32'hFE000EE3, 1'b1, 32'h0000001C};
    vecs[2] = '{32'h00000020, 32'h00000463, 1'b0, 32'h00000024};
    vecs[3] = '{32'h00000040, 32'h000000E7, 1'b0, 32'h00000044};
    vecs[4] = '{32'h00000100, 32'h00A00093, 1'b0, 32'h00000104};
    vecs[5] = '{32'hFFFFFFFC, 32'h0080006F, 1'b1, 32'h00000004};
    vecs[6] = '{32'h00000000, 32'hFE000EE3, 1'b1, 32'hFFFFFFFC};

    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; clear_pc = '0;
    icache_req_ready = 1'b0; icache_resp_valid = 1'b0; icache_resp_inst = '0;
    iq_ready = 1'b0;
    tick();
    tick();
    chk("reset_req_valid", icache_req_valid, 0);
    chk("reset_iq_valid", iq_valid, 0);
    chk("reset_addr", icache_req_addr, 32'h0);
    chk("reset_iq_pc", iq_pc, 32'h0);
    rst_in = 1'b0;
    tick();
    chk("post_reset_req_valid", icache_req_valid, 1);

    // First fetch out of reset
    fetch(32'h00000013, 1'b0, 32'h4, 1'b0);
    chk("t1_next_addr", icache_req_addr, 32'h4);
    pop_check();
    chk("t1_empty_after_pop", iq_valid, 0);

    // Prediction table, each vector fetched from its own redirect target
    for (int i = 0; i < 7; i++) begin
      redirect(vecs[i].start_pc);
      fetch(vecs[i].inst, vecs[i].taken, vecs[i].pred_pc, 1'b0);
      chk("vec_next_addr", icache_req_addr, vecs[i].pred_pc);
      pop_check();
      chk("vec_empty_after_pop", iq_valid, 0);
    end

    // Fill the queue, confirm the stall, then push+pop in one cycle
    redirect(32'h200);
    for (int i = 0; i < 8; i++) begin
      fetch(32'h00000013, 1'b0, 32'h200 + 32'(4 * i + 4), 1'b0);
    end
    chk("full_req_low", icache_req_valid, 0);
    tick(); tick(); tick();
    chk("full_req_still_low", icache_req_valid, 0);
    pop_check();
    chk("req_resumes_after_pop", icache_req_valid, 1);
    fetch(32'h00000013, 1'b0, 32'h224, 1'b1);
    chk("pushpop_keeps_count", icache_req_valid, 1);
    fetch(32'h00000013, 1'b0, 32'h228, 1'b0);
    chk("refilled_req_low", icache_req_valid, 0);
    for (int i = 0; i < 8; i++) pop_check();
    chk("drained_empty", iq_valid, 0);

    // Flush while a request is outstanding: the late word must vanish
    redirect(32'h300);
    fetch(32'h00000013, 1'b0, 32'h304, 1'b0);
    fetch(32'h00000013, 1'b0, 32'h308, 1'b0);
    icache_req_ready = 1'b1;
    tick();
    icache_req_ready = 1'b0;
    clear_in = 1'b1;
    clear_pc = 32'h100;
    tick();
    clear_in = 1'b0;
    sb.delete();
    chk("flush_queue_empty", iq_valid, 0);
    chk("flush_drop_no_req", icache_req_valid, 0);
    tick();
    icache_resp_valid = 1'b1;
    icache_resp_inst  = 32'h0080006F;
    tick();
    icache_resp_valid = 1'b0;
    chk("late_resp_discarded", iq_valid, 0);
    chk("flush_req_valid", icache_req_valid, 1);
    chk("flush_req_addr", icache_req_addr, 32'h100);
    fetch(32'h00000013, 1'b0, 32'h104, 1'b0);
    pop_check();
    chk("no_stale_entry", iq_valid, 0);

    // Freeze mid-WAIT: pop and response pulse are both ignored
    redirect(32'h400);
    fetch(32'h00000013, 1'b0, 32'h404, 1'b0);
    icache_req_ready = 1'b1;
    tick();
    icache_req_ready = 1'b0;
    rdy_in   = 1'b0;
    iq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      icache_resp_valid = (i == 2);
      icache_resp_inst  = 32'h00000013;
      tick();
    end
    icache_resp_valid = 1'b0;
    chk("freeze_iq_valid", iq_valid, 1);
    chk("freeze_iq_pc", iq_pc, 32'h400);
    chk("freeze_req_low", icache_req_valid, 0);
    chk("freeze_addr", icache_req_addr, 32'h404);
    rdy_in   = 1'b1;
    iq_ready = 1'b0;
    tick();
    sb.push_back('{32'h0080006F, 32'h404, 1'b1, 32'h40C});
    icache_resp_valid = 1'b1;
    icache_resp_inst  = 32'h0080006F;
    tick();
    icache_resp_valid = 1'b0;
    chk("unfreeze_next_addr", icache_req_addr, 32'h40C);
    pop_check();
    pop_check();

    // Reset with four entries queued
    for (int i = 0; i < 4; i++) begin
      fetch(32'h00000013, 1'b0, 32'h40C + 32'(4 * i + 4), 1'b0);
    end
    chk("pre_reset_iq_valid", iq_valid, 1);
    rst_in = 1'b1;
    tick();
    chk("rst_iq_empty", iq_valid, 0);
    chk("rst_addr", icache_req_addr, 32'h0);
    chk("rst_req_low", icache_req_valid, 0);
    rst_in = 1'b0;
    sb.delete();
    tick();
    chk("rst_release_req", icache_req_valid, 1);
    chk("rst_release_addr", icache_req_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
